// File: rtl/register_wb_buf.sv
// Buffered writeback stage: decodes writeback ops into register writes, queues them in a FIFO and presents them through a hold-aware output stage.
// Optional macro REGISTER_WB_BUF_FWD_EN enables youngest-pending-write data on qdata.
module register_wb_buf #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DW-1:0]                r1,
  input  logic [DW-1:0]                r2,
  input  logic [AW-1:0]                a1,
  input  logic [AW-1:0]                a2,
  input  logic [3:0]                   op,
  input  logic                         proceed,
  output logic                         ready,
  input  logic                         hold,
  output logic [1:0]                   write,
  output logic [DW-1:0]                wr1,
  output logic [DW-1:0]                wr2,
  output logic [AW-1:0]                wa1,
  output logic [AW-1:0]                wa2,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  input  logic [AW-1:0]                qa,
  output logic                         qhit,
  output logic [DW-1:0]                qdata
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]    mask;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wr1;
    logic [AW-1:0] wa2;
    logic [DW-1:0] wr2;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  entry_t        dec_c;
  logic          occupied;
  logic          load;
  logic          push;
  logic          pop;

  // Op decode into one or two register writes
  always_comb begin
    dec_c = '0;
    case (op)
      4'd1: begin dec_c.mask = 2'b01; dec_c.wa1 = a1;          dec_c.wr1 = r1; end
      4'd2: begin dec_c.mask = 2'b01; dec_c.wa1 = a2;          dec_c.wr1 = r1; end
      4'd3: begin dec_c.mask = 2'b01; dec_c.wa1 = r2[AW-1:0];  dec_c.wr1 = r1; end
      4'd4: begin dec_c.mask = 2'b01; dec_c.wa1 = a1;          dec_c.wr1 = r2; end
      4'd5: begin dec_c.mask = 2'b01; dec_c.wa1 = a2;          dec_c.wr1 = r2; end
      4'd6: begin dec_c.mask = 2'b01; dec_c.wa1 = r1[AW-1:0];  dec_c.wr1 = r2; end
      4'd7: begin
        dec_c.mask = 2'b11;
        dec_c.wa1  = a1; dec_c.wr1 = r1;
        dec_c.wa2  = a2; dec_c.wr2 = r2;
      end
      4'd8: begin
        dec_c.mask = 2'b11;
        dec_c.wa1  = a2; dec_c.wr1 = r1;
        dec_c.wa2  = a1; dec_c.wr2 = r2;
      end
      default: dec_c = '0;
    endcase
  end

  assign ready    = (level < LW'(DEPTH));
  assign occupied = (write != 2'b00);
  assign load     = !occupied || !hold;
  assign push     = !rst && proceed && ready && (dec_c.mask != 2'b00);
  assign pop      = load && (level != '0);

  // FIFO storage carries no reset; validity is tracked by level
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= dec_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      write <= '0;
      wr1   <= '0;
      wr2   <= '0;
      wa1   <= '0;
      wa2   <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (load) begin
        if (level != '0) begin
          write <= mem[rptr].mask;
          wa1   <= mem[rptr].wa1;
          wr1   <= mem[rptr].wr1;
          wa2   <= mem[rptr].wa2;
          wr2   <= mem[rptr].wr2;
        end else begin
          write <= '0;
          wa1   <= '0;
          wr1   <= '0;
          wa2   <= '0;
          wr2   <= '0;
        end
      end
    end
  end

  // Hazard query: later matches override earlier ones, so the youngest write wins
  always_comb begin
    entry_t        e;
    logic [PW-1:0] slot;
    e     = '0;
    slot  = '0;
    qhit  = 1'b0;
    qdata = '0;
    if (write[0] && (wa1 == qa)) begin
      qhit = 1'b1;
`ifdef REGISTER_WB_BUF_FWD_EN
      qdata = wr1;
`endif
    end
    if (write[1] && (wa2 == qa)) begin
      qhit = 1'b1;
`ifdef REGISTER_WB_BUF_FWD_EN
      qdata = wr2;
`endif
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = rptr + PW'(i);
      e    = mem[slot];
      if (LW'(i) < level) begin
        if (e.mask[0] && (e.wa1 == qa)) begin
          qhit = 1'b1;
`ifdef REGISTER_WB_BUF_FWD_EN
          qdata = e.wr1;
`endif
        end
        if (e.mask[1] && (e.wa2 == qa)) begin
          qhit = 1'b1;
`ifdef REGISTER_WB_BUF_FWD_EN
          qdata = e.wr2;
`endif
        end
      end
    end
  end

endmodule
